hid_report_parser: RTL and testbench



---
 rtl/hid_report_parser.sv | 204 ++++++++++++++++++++
 tb/tb_hid_report_parser.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hid_report_parser.sv
// rtl/hid_report_parser.sv - boot-protocol mouse report reassembler with framing and timeout checks
//
// Purpose:
//   Collects the byte stream of a boot-protocol mouse report (buttons, X, Y,
//   optional wheel) into one parallel report word with a valid/ready handshake.
//   Packets of the wrong length are flagged on err_len. A report that stalls
//   between bytes for TIMEOUT_CYCLES cycles is discarded and flagged on
//   err_timeout. Good reports are counted in rpt_count, which saturates.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rx_data/rx_valid/
//   rx_last/rx_ready        inbound byte stream; rx_last marks the packet end
//   usb_configured          low flushes the parser and sinks every byte
//   rpt_buttons/x/y/wheel   assembled report (X/Y/wheel are signed)
//   rpt_valid/rpt_ready     report handshake
//   err_len, err_timeout    one-cycle error pulses
//   rpt_count               saturating count of good reports
//
// Optional feature (macro HID_ACCUM_EN):
//   rx_ready is never throttled by a pending report. A report that completes
//   while an earlier one is still held, with no handshake that cycle, is merged
//   into it: X/Y/wheel add with signed saturation to [-127, +127] and the
//   buttons take the newest value. Without the macro, a pending report
//   back-pressures the byte stream.
module hid_report_parser #(
  parameter int unsigned HAS_WHEEL      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_last,
  output logic        rx_ready,
  input  logic        usb_configured,
  output logic [2:0]  rpt_buttons,
  output logic [7:0]  rpt_x,
  output logic [7:0]  rpt_y,
  output logic [7:0]  rpt_wheel,
  output logic        rpt_valid,
  input  logic        rpt_ready,
  output logic        err_len,
  output logic        err_timeout,
  output logic [15:0] rpt_count
);

  localparam bit                WHL      = (HAS_WHEEL != 0);
  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_BTN, S_X, S_Y, S_WHL, S_DROP} state_e;

  state_e           state_q;
  logic [2:0]       btn_sh_q;
  logic [7:0]       x_sh_q;
  logic [7:0]       y_sh_q;
  logic [CNT_W-1:0] tmo_cnt_q;

  logic [2:0]       rpt_buttons_q;
  logic [7:0]       rpt_x_q;
  logic [7:0]       rpt_y_q;
  logic [7:0]       rpt_wheel_q;
  logic             rpt_valid_q;
  logic             err_len_q;
  logic             err_timeout_q;
  logic [15:0]      rpt_count_q;

  logic             accept;
  logic             handshake;
  logic             final_byte;
  logic [7:0]       y_new;
  logic [7:0]       w_new;
  logic [7:0]       x_d;
  logic [7:0]       y_d;
  logic [7:0]       w_d;

`ifdef HID_ACCUM_EN
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] s;
    s = $signed({a[7], a}) + $signed({b[7], b});
    if (s > 9'sd127)       return 8'h7F;
    else if (s < -9'sd127) return 8'h81;
    else                   return s[7:0];
  endfunction

  assign rx_ready = 1'b1;
`else
  // While unconfigured every byte is sunk, so the stream is never stalled.
  assign rx_ready = !usb_configured || !rpt_valid_q || rpt_ready;
`endif

  assign accept     = rx_valid && rx_ready && usb_configured;
  assign handshake  = rpt_valid_q && rpt_ready;
  assign final_byte = (state_q == S_WHL) || ((state_q == S_Y) && !WHL);

  always_comb begin
    // On the final byte the last field comes straight from rx_data.
    y_new = WHL ? y_sh_q  : rx_data;
    w_new = WHL ? rx_data : 8'h00;
    x_d   = x_sh_q;
    y_d   = y_new;
    w_d   = w_new;
`ifdef HID_ACCUM_EN
    if (rpt_valid_q && !rpt_ready) begin
      x_d = sat_add(rpt_x_q, x_sh_q);
      y_d = sat_add(rpt_y_q, y_new);
      w_d = sat_add(rpt_wheel_q, w_new);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BTN;
      btn_sh_q      <= '0;
      x_sh_q        <= '0;
      y_sh_q        <= '0;
      tmo_cnt_q     <= '0;
      rpt_buttons_q <= '0;
      rpt_x_q       <= '0;
      rpt_y_q       <= '0;
      rpt_wheel_q   <= '0;
      rpt_valid_q   <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      rpt_count_q   <= '0;
    end else begin
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      if (handshake) begin
        rpt_valid_q <= 1'b0;
      end

      if (!usb_configured) begin
        state_q     <= S_BTN;
        tmo_cnt_q   <= '0;
        rpt_valid_q <= 1'b0;
      end else if (accept) begin
        tmo_cnt_q <= '0;
        if (state_q == S_DROP) begin
          if (rx_last) begin
            state_q <= S_BTN;
          end
        end else if (final_byte) begin
          if (rx_last) begin
            // Later assignment overrides the handshake clear: no gap.
            rpt_buttons_q <= btn_sh_q;
            rpt_x_q       <= x_d;
            rpt_y_q       <= y_d;
            rpt_wheel_q   <= w_d;
            rpt_valid_q   <= 1'b1;
            if (rpt_count_q != 16'hFFFF) begin
              rpt_count_q <= rpt_count_q + 16'd1;
            end
            state_q <= S_BTN;
          end else begin
            err_len_q <= 1'b1;
            state_q   <= S_DROP;
          end
        end else if (rx_last) begin
          err_len_q <= 1'b1;
          state_q   <= S_BTN;
        end else begin
          case (state_q)
            S_BTN: begin
              btn_sh_q <= rx_data[2:0];
              state_q  <= S_X;
            end
            S_X: begin
              x_sh_q  <= rx_data;
              state_q <= S_Y;
            end
            default: begin
              y_sh_q  <= rx_data;
              state_q <= S_WHL;
            end
          endcase
        end
      end else if (state_q == S_BTN) begin
        tmo_cnt_q <= '0;
      end else if (rx_ready) begin
        // Idle cycle inside a report; cycles stalled by back-pressure do not count.
        if (tmo_cnt_q == TMO_LAST) begin
          err_timeout_q <= 1'b1;
          tmo_cnt_q     <= '0;
          state_q       <= S_BTN;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign rpt_buttons = rpt_buttons_q;
  assign rpt_x       = rpt_x_q;
  assign rpt_y       = rpt_y_q;
  assign rpt_wheel   = rpt_wheel_q;
  assign rpt_valid   = rpt_valid_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign rpt_count   = rpt_count_q;

endmodule

// File: tb/tb_hid_report_parser.sv
// tb/tb_hid_report_parser.sv - self-checking bench for hid_report_parser
module tb_hid_report_parser;

  localparam int TO   = 16;
  localparam int NPKT = 60;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic        rx_ready;
  logic        usb_configured;
  logic [2:0]  rpt_buttons;
  logic [7:0]  rpt_x;
  logic [7:0]  rpt_y;
  logic [7:0]  rpt_wheel;
  logic        rpt_valid;
  logic        rpt_ready;
  logic        err_len;
  logic        err_timeout;
  logic [15:0] rpt_count;

  hid_report_parser #(.HAS_WHEEL(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
    .usb_configured(usb_configured),
    .rpt_buttons(rpt_buttons), .rpt_x(rpt_x), .rpt_y(rpt_y), .rpt_wheel(rpt_wheel),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .err_len(err_len), .err_timeout(err_timeout), .rpt_count(rpt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] b;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] w;
  } rpt_t;

  typedef struct {
    int          len;
    logic [47:0] bytes;
    logic        good;
    logic [2:0]  btn;
    logic [7:0]  x, y, w;
    int          nerr;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   err_len_seen = 0;
  int   err_tmo_seen = 0;
  int   exp_count = 0;
  bit   rand_rdy = 0;
  bit   mon_en = 0;
  bit   prev_hold = 0;
  rpt_t prev_rpt;
  rpt_t obs_q[$];
  rpt_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rpt_ready = ($urandom_range(0, 1) == 1);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    rx_data  = d;
    rx_last  = l;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) chk("rx_ready_wait_bound", 32'd0, 32'd1);
    tick();
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [47:0] bytes, input int len);
    for (int j = 0; j < len; j++) send_byte(bytes[47-8*j -: 8], (j == len - 1));
  endtask

  task automatic chk_rpt(input string n, input logic [2:0] b, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] w);
    chk({n, "_valid"}, rpt_valid, 1);
    chk({n, "_btn"}, rpt_buttons, b);
    chk({n, "_x"}, rpt_x, x);
    chk({n, "_y"}, rpt_y, y);
    chk({n, "_w"}, rpt_wheel, w);
    chk({n, "_count"}, rpt_count, exp_count);
  endtask

  // Observes error pulses, report stability while held, and handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 0;
    end else begin
      if (err_len) err_len_seen++;
      if (err_timeout) err_tmo_seen++;
      if (err_len || err_timeout) begin
        tests++;
        if (err_len && err_timeout) begin
          fails++;
          $display("FAIL err_overlap: err_len=1 err_timeout=1, at most one allowed");
        end
      end
`ifndef HID_ACCUM_EN
      if (prev_hold) begin
        tests++;
        if (!rpt_valid || {rpt_buttons, rpt_x, rpt_y, rpt_wheel} !== prev_rpt) begin
          fails++;
          $display("FAIL hold_stable: got valid=%0d rpt=0x%0h, expected valid=1 rpt=0x%0h",
                   rpt_valid, {rpt_buttons, rpt_x, rpt_y, rpt_wheel}, prev_rpt);
        end
      end
`endif
      if (mon_en && rpt_valid && rpt_ready) obs_q.push_back({rpt_buttons, rpt_x, rpt_y, rpt_wheel});
      prev_hold = rpt_valid && !rpt_ready && usb_configured;
      prev_rpt  = {rpt_buttons, rpt_x, rpt_y, rpt_wheel};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [10];
    int   e0, t0, len, exp_err, bad;
    logic [7:0] b [6];

    vt[0] = '{4, 48'h05_10_F0_01_00_00, 1'b1, 3'b101, 8'h10, 8'hF0, 8'h01, 0};
    vt[1] = '{2, 48'h01_02_00_00_00_00, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1};
    vt[2] = '{4, 48'hFF_7F_80_FF_00_00, 1'b1, 3'b111, 8'h7F, 8'h80, 8'hFF, 0};
    vt[3] = '{6, 48'h11_22_33_44_55_66, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1};
    vt[4] = '{4, 48'h08_01_02_03_00_00, 1'b1, 3'b000, 8'h01, 8'h02, 8'h03, 0};
    vt[5] = '{1, 48'hAA_00_00_00_00_00, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1};
    vt[6] = '{4, 48'h02_FE_00_80_00_00, 1'b1, 3'b010, 8'hFE, 8'h00, 8'h80, 0};
    vt[7] = '{3, 48'h01_02_03_00_00_00, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1};
    vt[8] = '{5, 48'h04_05_06_07_08_00, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1};
    vt[9] = '{4, 48'h06_81_7F_00_00_00, 1'b1, 3'b110, 8'h81, 8'h7F, 8'h00, 0};

    rst_n = 0; rx_data = 0; rx_valid = 0; rx_last = 0;
    usb_configured = 1; rpt_ready = 1;
    tick(); tick();
    chk("rst_rpt_valid", rpt_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_count", rpt_count, 0);
    chk("rst_errs", {err_len, err_timeout}, 0);
    chk("rst_rpt", {rpt_buttons, rpt_x, rpt_y, rpt_wheel}, 0);
    rst_n = 1;
    tick();

    // Table of packets, consumer always ready.
    for (int i = 0; i < 10; i++) begin
      e0 = err_len_seen;
      send_pkt(vt[i].bytes, vt[i].len);
      chk($sformatf("vec%0d_valid", i), rpt_valid, vt[i].good);
      if (vt[i].good) begin
        exp_count++;
        chk_rpt($sformatf("vec%0d", i), vt[i].btn, vt[i].x, vt[i].y, vt[i].w);
      end
      tick(); tick();
      chk($sformatf("vec%0d_errlen", i), err_len_seen - e0, vt[i].nerr);
    end

    // Inter-byte timeout after two bytes.
    e0 = err_len_seen; t0 = err_tmo_seen; bad = 0;
    send_byte(8'h05, 0);
    send_byte(8'h10, 0);
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k < TO) bad = bad | int'(err_timeout);
      else chk("tmo_pulse", err_timeout, 1);
    end
    chk("tmo_early", bad, 0);
    tick();
    chk("tmo_one_cycle", err_timeout, 0);
    chk("tmo_no_rpt", rpt_valid, 0);
    chk("tmo_count_pulses", err_tmo_seen - t0, 1);
    send_pkt(48'h03_20_30_40_00_00, 4);
    exp_count++;
    chk_rpt("tmo_next", 3'b011, 8'h20, 8'h30, 8'h40);
    chk("tmo_no_errlen", err_len_seen - e0, 0);
    tick();

    // Consumer stalls for 20 cycles while a second packet is offered.
    rpt_ready = 0;
    send_pkt(48'h01_70_90_00_00_00, 4);
    exp_count++;
    chk_rpt("bp_first", 3'b001, 8'h70, 8'h90, 8'h00);
`ifdef HID_ACCUM_EN
    send_pkt(48'h02_70_90_00_00_00, 4);
    exp_count++;
    chk_rpt("acc_sum", 3'b010, 8'h7F, 8'h81, 8'h00);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      bad = bad | int'(!rx_ready) | int'(rpt_x !== 8'h7F);
    end
    chk("acc_stall", bad, 0);
    rpt_ready = 1;
    tick();
    chk("acc_drained", rpt_valid, 0);
`else
    bad = 0;
    rx_data = 8'h02; rx_valid = 1; rx_last = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      bad = bad | int'(rx_ready !== 1'b0) | int'(rpt_x !== 8'h70) | int'(rpt_y !== 8'h90);
    end
    chk("bp_stall", bad, 0);
    rpt_ready = 1;
    #1;
    send_byte(8'h02, 0);
    chk("bp_handshake", rpt_valid, 0);
    send_byte(8'h70, 0);
    send_byte(8'h90, 0);
    send_byte(8'h00, 1);
    exp_count++;
    chk_rpt("bp_second", 3'b010, 8'h70, 8'h90, 8'h00);
`endif
    tick();

    // Deconfigure mid-packet, then while a report is pending.
    e0 = err_len_seen; t0 = err_tmo_seen;
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    usb_configured = 0;
    tick();
    chk("cfg_rx_ready", rx_ready, 1);
    send_byte(8'h20, 0);
    send_byte(8'h30, 1);
    chk("cfg_no_rpt", rpt_valid, 0);
    chk("cfg_count", rpt_count, exp_count);
    repeat (TO + 2) tick();
    chk("cfg_no_err", (err_len_seen - e0) + (err_tmo_seen - t0), 0);
    usb_configured = 1;
    tick();
    send_pkt(48'h03_05_06_07_00_00, 4);
    exp_count++;
    chk_rpt("cfg_clean1", 3'b011, 8'h05, 8'h06, 8'h07);
    tick();
    rpt_ready = 0;
    send_pkt(48'h01_11_22_33_00_00, 4);
    exp_count++;
    usb_configured = 0;
    tick();
    chk("cfg_drop_valid", rpt_valid, 0);
    chk("cfg_drop_ready", rx_ready, 1);
    chk("cfg_drop_count", rpt_count, exp_count);
    usb_configured = 1; rpt_ready = 1;
    tick();
    send_pkt(48'h04_44_55_66_00_00, 4);
    exp_count++;
    chk_rpt("cfg_clean2", 3'b100, 8'h44, 8'h55, 8'h66);
    tick();

    // Asynchronous reset mid-report, then mid-handshake.
    send_byte(8'h07, 0);
    send_byte(8'h33, 0);
    #1 rst_n = 0;
    #1 chk("arst_count", rpt_count, 0);
    exp_count = 0;
    #2 rst_n = 1;
    tick();
    send_pkt(48'h01_0A_0B_0C_00_00, 4);
    exp_count++;
    chk_rpt("arst_clean", 3'b001, 8'h0A, 8'h0B, 8'h0C);
    rpt_ready = 0;
    tick();
    #1 rst_n = 0;
    #1 chk("arst_valid", rpt_valid, 0);
    chk("arst_rx_ready", rx_ready, 1);
    chk("arst_rpt", {rpt_buttons, rpt_x, rpt_y, rpt_wheel}, 0);
    exp_count = 0;
    #2 rst_n = 1;
    rpt_ready = 1;
    tick();

    // Random packets against a packet-level model.
    e0 = err_len_seen; t0 = err_tmo_seen; exp_err = 0;
    obs_q.delete(); exp_q.delete();
`ifndef HID_ACCUM_EN
    rand_rdy = 1;
`endif
    mon_en = 1;
    for (int p = 0; p < NPKT; p++) begin
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 4;
      for (int j = 0; j < 6; j++) b[j] = 8'($urandom);
      if (len == 4) begin
        exp_q.push_back({b[0][2:0], b[1], b[2], b[3]});
        exp_count++;
      end else begin
        exp_err++;
      end
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_byte(b[j], (j == len - 1));
      end
    end
    rand_rdy = 0; rpt_ready = 1;
    repeat (5) tick();
    mon_en = 0;
    chk("rnd_nrpt", obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      chk($sformatf("rnd_rpt%0d", k), obs_q[k], exp_q[k]);
    chk("rnd_errlen", err_len_seen - e0, exp_err);
    chk("rnd_errtmo", err_tmo_seen - t0, 0);
    chk("rnd_count", rpt_count, exp_count);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
